// File: rtl/life_frame_capture.sv
// life_frame_capture: collects ROWS consecutive COLS-bit rows of a life board into one frame.
// Latency: frame_valid rises the cycle after the last row (ROWS-1) is accepted.
// Backpressure: frame held in HOLD until frame_valid&frame_ready; new frames arriving meanwhile are dropped and counted.
//
// Optional feature macro: LIFE_FRAME_CAPTURE_STILL_DETECT_EN
//   defined   -> a previous-frame store is loaded on every handshake and still_life reports
//                whether the frame now on frame_out matches the previously delivered one.
//   undefined -> no previous-frame store; still_life is tied low.
//
// Ports:
//   clk          in   1             sole clock, rising edge
//   rst          in   1             synchronous active-high reset, dominates every input
//   row_in       in   COLS          one board row, 1 = live cell
//   row_valid    in   1             row_in carries a row this cycle
//   sof          in   1             row_in is row 0 of a frame (only meaningful with row_valid)
//   frame_ready  in   1             downstream accepts frame_out this cycle
//   frame_valid  out  1             frame_out / live_count / still_life are valid
//   frame_out    out  ROWS*COLS     assembled frame, row r at bits [r*COLS +: COLS]
//   live_count   out  clog2(N+1)    popcount of frame_out
//   still_life   out  1             frame_out equals the previously delivered frame
//   frame_error  out  1             one-cycle pulse: sof arrived while a frame was half collected
//   drop_count   out  8             saturating count of frames dropped while holding

module life_frame_capture #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [COLS-1:0]                   row_in,
  input  logic                              row_valid,
  input  logic                              sof,
  input  logic                              frame_ready,
  output logic                              frame_valid,
  output logic [ROWS*COLS-1:0]              frame_out,
  output logic [$clog2(ROWS*COLS+1)-1:0]    live_count,
  output logic                              still_life,
  output logic                              frame_error,
  output logic [7:0]                        drop_count
);

  localparam int NBITS = ROWS * COLS;
  localparam int CW    = $clog2(NBITS + 1);
  localparam int IW    = $clog2(ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [IW-1:0]     r_idx;         // index of the next row to be stored
  logic [NBITS-1:0]  r_buf;         // frame under assembly
  logic [NBITS-1:0]  r_frame_out;   // frame presented downstream
  logic [CW-1:0]     r_live_count;
  logic              r_frame_valid;
  logic              r_frame_error;
  logic [7:0]        r_drop_count;

  // ------------------------------------------------------------------
  // Decode
  // ------------------------------------------------------------------
  logic              w_sof_row;
  logic              w_data_row;
  logic              w_last_row;
  logic              w_handshake;
  logic [NBITS-1:0]  w_next_frame;
  logic [CW-1:0]     w_popcount;
  logic [NBITS-1:0]  w_first_row;

  assign w_sof_row   = row_valid & sof;
  assign w_data_row  = row_valid & ~sof;
  assign w_last_row  = (r_state == S_FILL) & w_data_row & (r_idx == LAST_IDX);
  assign w_handshake = (r_state == S_HOLD) & frame_ready;

  // A new frame always starts from a cleared buffer holding only row 0,
  // so nothing from an abandoned partial frame can leak into the next one.
  assign w_first_row = {{(NBITS - COLS){1'b0}}, row_in};

  // The frame as it will look once the incoming last row is written; used
  // to load frame_out, the popcount and the still-life compare on the same
  // edge, which is what gives a one-cycle latency to frame_valid.
  always_comb begin
    w_next_frame = r_buf;
    w_next_frame[(ROWS-1)*COLS +: COLS] = row_in;
  end

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < NBITS; i++) begin
      w_popcount = w_popcount + CW'(w_next_frame[i]);
    end
  end

  // ------------------------------------------------------------------
  // Capture FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_buf         <= '0;
      r_frame_out   <= '0;
      r_live_count  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_drop_count  <= 8'd0;
    end else begin
      r_frame_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Rows without sof are mid-frame leftovers; ignore them.
          if (w_sof_row) begin
            r_buf   <= w_first_row;
            r_idx   <= IW'(1);
            r_state <= S_FILL;
          end
        end

        S_FILL: begin
          if (w_sof_row) begin
            // Restart: the partial frame is abandoned, this row is row 0.
            r_frame_error <= 1'b1;
            r_buf         <= w_first_row;
            r_idx         <= IW'(1);
          end else if (w_data_row) begin
            r_buf[r_idx*COLS +: COLS] <= row_in;
            if (w_last_row) begin
              r_state       <= S_HOLD;
              r_idx         <= '0;
              r_frame_valid <= 1'b1;
              r_frame_out   <= w_next_frame;
              r_live_count  <= w_popcount;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end

        S_HOLD: begin
          if (w_handshake) begin
            r_frame_valid <= 1'b0;
            // A sof coinciding with the handshake is not lost: it starts
            // the next frame directly.
            if (w_sof_row) begin
              r_buf   <= w_first_row;
              r_idx   <= IW'(1);
              r_state <= S_FILL;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_sof_row && (r_drop_count != 8'hFF)) begin
            // Each sof seen while stalled is one whole frame we cannot take.
            // Its remaining rows fall into IDLE later and are ignored there.
            r_drop_count <= r_drop_count + 8'd1;
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Still-life detection
  // ------------------------------------------------------------------
`ifdef LIFE_FRAME_CAPTURE_STILL_DETECT_EN
  logic [NBITS-1:0] r_prev;
  logic             r_prev_vld;
  logic             r_still;

  // The store is refreshed on the handshake, which always precedes the
  // completion of the following frame by at least ROWS-1 cycles, so the
  // compare at completion sees the frame that was really delivered last.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_still    <= 1'b0;
    end else begin
      if (w_last_row) begin
        r_still <= r_prev_vld && (w_next_frame == r_prev);
      end
      if (w_handshake) begin
        r_prev     <= r_frame_out;
        r_prev_vld <= 1'b1;
      end
    end
  end

  assign still_life = r_still;
`else
  assign still_life = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign frame_valid = r_frame_valid;
  assign frame_out   = r_frame_out;
  assign live_count  = r_live_count;
  assign frame_error = r_frame_error;
  assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_life_frame_capture.sv
// Bench for life_frame_capture: directed frames, expected deliveries queued and
// checked by a monitor on each handshake; direct checks for reset, latency,
// frame_error, drop counting and reset mid-frame.
module tb_life_frame_capture;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = $clog2(ROWS*COLS+1);
`ifdef LIFE_FRAME_CAPTURE_STILL_DETECT_EN
  localparam bit STILL_EN = 1'b1;
`else
  localparam bit STILL_EN = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [COLS-1:0]        row_in;
  logic                   row_valid;
  logic                   sof;
  logic                   frame_ready;
  logic                   frame_valid;
  logic [ROWS*COLS-1:0]   frame_out;
  logic [CW-1:0]          live_count;
  logic                   still_life;
  logic                   frame_error;
  logic [7:0]             drop_count;

  life_frame_capture #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .row_valid(row_valid), .sof(sof),
    .frame_ready(frame_ready), .frame_valid(frame_valid), .frame_out(frame_out),
    .live_count(live_count), .still_life(still_life), .frame_error(frame_error),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] f;
    int          cnt;
    bit          still;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   err_cycles;

  localparam logic [63:0] F_DIAG = 64'h8040201008040201;
  localparam logic [63:0] F_DIAG2 = 64'h8040201008040203;
  localparam logic [63:0] F_ONES = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] F_MIX = 64'hFFAA55CC33F00F00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] f, input int cnt, input bit still);
    exp_t e;
    e.f = f; e.cnt = cnt; e.still = still;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_error) err_cycles++;
      if (frame_valid && frame_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame %0h expected no delivery", frame_out);
        end else begin
          e = exp_q.pop_front();
          chk("frame_out", frame_out, e.f);
          chk("live_count", 64'(live_count), 64'(e.cnt));
          chk("still_life", 64'(still_life), 64'(e.still));
        end
      end
    end
  endtask

  task automatic send_row(input logic [7:0] r, input bit s);
    row_in = r; sof = s; row_valid = 1'b1;
    @(posedge clk); #1;
    row_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] f);
    for (int i = 0; i < ROWS; i++) send_row(f[i*8 +: 8], i == 0);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks = 0; errors = 0; err_cycles = 0;
    rst = 1'b1; row_in = '0; row_valid = 1'b0; sof = 1'b0; frame_ready = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_out", frame_out, 64'd0);
    chk("rst_live_count", 64'(live_count), 64'd0);
    chk("rst_still_life", 64'(still_life), 64'd0);
    chk("rst_frame_error", 64'(frame_error), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    @(posedge clk); #1;

    // Diagonal frame, downstream always ready.
    frame_ready = 1'b1;
    push_exp(F_DIAG, 8, 1'b0);
    send_frame(F_DIAG);
    chk("latency_valid", 64'(frame_valid), 64'd1);
    @(posedge clk); #1;
    chk("valid_drop_after_hs", 64'(frame_valid), 64'd0);
    wait_empty(20);

    // Repeat, one-cell change, then repeat of the changed frame.
    push_exp(F_DIAG, 8, STILL_EN);
    send_frame(F_DIAG);
    wait_empty(20);
    push_exp(F_DIAG2, 9, 1'b0);
    send_frame(F_DIAG2);
    wait_empty(20);
    push_exp(F_DIAG2, 9, STILL_EN);
    send_frame(F_DIAG2);
    wait_empty(20);

    // Aborted frame: sof plus 2 rows, then a full frame of ones.
    send_row(8'hAA, 1'b1);
    send_row(8'h55, 1'b0);
    send_row(8'h0F, 1'b0);
    push_exp(F_ONES, 64, 1'b0);
    send_row(8'hFF, 1'b1);
    chk("frame_error_timing", 64'(frame_error), 64'd1);
    for (int i = 1; i < ROWS; i++) send_row(8'hFF, 1'b0);
    wait_empty(20);
    chk("frame_error_pulses", 64'(err_cycles), 64'd1);

    // Stall downstream, drop 300 frames.
    frame_ready = 1'b0;
    push_exp(F_MIX, 32, 1'b0);
    send_frame(F_MIX);
    chk("hold_valid", 64'(frame_valid), 64'd1);
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < ROWS; i++) send_row(8'(k*3 + i*37 + 1), i == 0);
      if (k == 9) chk("drop_count_10", 64'(drop_count), 64'd10);
    end
    @(negedge clk);
    chk("hold_frame_out", frame_out, F_MIX);
    chk("hold_live_count", 64'(live_count), 64'd32);
    chk("hold_still_valid", 64'(frame_valid), 64'd1);
    chk("drop_count_sat", 64'(drop_count), 64'd255);
    chk("no_error_in_hold", 64'(err_cycles), 64'd1);
    @(posedge clk); #1;
    // Handshake and sof in the same cycle: that row starts the next frame.
    push_exp(F_MIX, 32, STILL_EN);
    frame_ready = 1'b1;
    send_row(F_MIX[7:0], 1'b1);
    chk("valid_low_after_hs_sof", 64'(frame_valid), 64'd0);
    for (int i = 1; i < ROWS; i++) send_row(F_MIX[i*8 +: 8], 1'b0);
    wait_empty(20);

    // Reset after row 5, reset coinciding with a sof row, then rows 6-7.
    for (int i = 0; i < 6; i++) send_row(F_ONES[i*8 +: 8], i == 0);
    rst = 1'b1;
    send_row(8'hFF, 1'b1);
    rst = 1'b0;
    send_row(8'hFF, 1'b0);
    send_row(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_valid_after_rst", 64'(frame_valid), 64'd0);
    end
    chk("rst2_frame_out", frame_out, 64'd0);
    chk("rst2_live_count", 64'(live_count), 64'd0);
    chk("rst2_still_life", 64'(still_life), 64'd0);
    chk("rst2_drop_count", 64'(drop_count), 64'd0);
    chk("rst2_frame_error", 64'(frame_error), 64'd0);
    @(posedge clk); #1;

    // Previous-frame store is invalid after reset.
    push_exp(F_MIX, 32, 1'b0);
    send_frame(F_MIX);
    wait_empty(20);
    push_exp(F_MIX, 32, STILL_EN);
    send_frame(F_MIX);
    wait_empty(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
